// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline sequencer and the stage datapath.
// The datapath side drives RR/EX/WB status; the sequencer drives enables.
interface pipe_hazard_ctrl_if #(
    parameter int IW    = 3,
    parameter int CNT_W = 16
);
    logic             rr_valid;
    logic             rr_src1_used;
    logic             rr_src2_used;
    logic [IW-1:0]    rr_src1_idx;
    logic [IW-1:0]    rr_src2_idx;
    logic             rr_dst_wr;
    logic [IW-1:0]    rr_dst_idx;
    logic             ex_busy;
    logic             ex_redirect;
    logic             wb_valid;
    logic             wb_wr;
    logic [IW-1:0]    wb_dst_idx;
    logic             wb_halt;
    logic             pc_en;
    logic             if_id_en;
    logic             id_rr_en;
    logic             rr_ex_en;
    logic             if_id_flush;
    logic             id_rr_flush;
    logic             rr_ex_bubble;
    logic             ex_wb_bubble;
    logic             issue;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rr_valid, rr_src1_used, rr_src2_used,
        output rr_src1_idx, rr_src2_idx,
        output rr_dst_wr, rr_dst_idx,
        output ex_busy, ex_redirect,
        output wb_valid, wb_wr, wb_dst_idx, wb_halt,
        input  pc_en, if_id_en, id_rr_en, rr_ex_en,
        input  if_id_flush, id_rr_flush,
        input  rr_ex_bubble, ex_wb_bubble,
        input  issue, halted, stall_cnt
    );

    modport slave (
        input  rr_valid, rr_src1_used, rr_src2_used,
        input  rr_src1_idx, rr_src2_idx,
        input  rr_dst_wr, rr_dst_idx,
        input  ex_busy, ex_redirect,
        input  wb_valid, wb_wr, wb_dst_idx, wb_halt,
        output pc_en, if_id_en, id_rr_en, rr_ex_en,
        output if_id_flush, id_rr_flush,
        output rr_ex_bubble, ex_wb_bubble,
        output issue, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: RAW scoreboard, stall/flush/bubble control,
// post-reset hold and sticky halt for the IF/ID/RR/EX/WB pipeline.
module pipe_hazard_ctrl #(
    parameter int NREGS      = 8,
    parameter int RESET_HOLD = 4,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int IW = $clog2(NREGS);
    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

    typedef enum logic [1:0] {HOLD, RUN, HALT} state_e;

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [1:0]       sb_q [NREGS];
    logic [1:0]       sb_d [NREGS];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NREGS-1:0] inc, dec;
    logic [1:0]       cnt1, cnt2;
    logic             wb_ret, halt_req;
    logic             haz1, haz2, hazard;
    logic             stall_ev;

    logic pc_en, if_id_en, id_rr_en, rr_ex_en;
    logic if_id_flush, id_rr_flush;
    logic rr_ex_bubble, ex_wb_bubble;
    logic issue, halted;

    assign wb_ret   = bus.wb_valid & bus.wb_wr;
    assign halt_req = bus.wb_valid & bus.wb_halt;
    assign cnt1     = sb_q[bus.rr_src1_idx];
    assign cnt2     = sb_q[bus.rr_src2_idx];

    // A single pending write retiring in WB this cycle is visible through
    // the write-through register file, so it does not block RR.
    assign haz1 = bus.rr_src1_used && (cnt1 != 2'd0) &&
                  !(cnt1 == 2'd1 && wb_ret &&
                    bus.wb_dst_idx == bus.rr_src1_idx);
    assign haz2 = bus.rr_src2_used && (cnt2 != 2'd0) &&
                  !(cnt2 == 2'd1 && wb_ret &&
                    bus.wb_dst_idx == bus.rr_src2_idx);
    assign hazard = haz1 | haz2;

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_rr_en     = 1'b0;
        rr_ex_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_rr_flush  = 1'b0;
        rr_ex_bubble = 1'b0;
        ex_wb_bubble = 1'b0;
        issue        = 1'b0;
        halted       = 1'b0;
        stall_ev     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (halt_req) begin
                    ex_wb_bubble = 1'b1;
                    halted       = 1'b1;
                end else if (bus.ex_busy) begin
                    ex_wb_bubble = 1'b1;
                    stall_ev     = 1'b1;
                end else if (bus.ex_redirect) begin
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    id_rr_en     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_rr_flush  = 1'b1;
                    rr_ex_en     = 1'b1;
                    rr_ex_bubble = 1'b1;
                end else if (hazard && bus.rr_valid) begin
                    rr_ex_en     = 1'b1;
                    rr_ex_bubble = 1'b1;
                    stall_ev     = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    id_rr_en = 1'b1;
                    rr_ex_en = 1'b1;
                    issue    = bus.rr_valid;
                end
            end
            HALT: begin
                ex_wb_bubble = 1'b1;
                halted       = 1'b1;
            end
            default: begin
                if_id_flush  = 1'b1;
                id_rr_flush  = 1'b1;
                rr_ex_en     = 1'b1;
                rr_ex_bubble = 1'b1;
                ex_wb_bubble = 1'b1;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            inc[i] = issue && bus.rr_dst_wr &&
                     bus.rr_dst_idx == IW'(i);
            dec[i] = wb_ret && bus.wb_dst_idx == IW'(i);
            sb_d[i] = sb_q[i];
            if (inc[i] && !dec[i]) begin
                sb_d[i] = sb_q[i] + 2'd1;
            end else if (dec[i] && !inc[i]) begin
                sb_d[i] = sb_q[i] - 2'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (stall_ev && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        unique case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end
            end
            HALT: state_d = HALT;
            default: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                sb_q[i] <= 2'd0;
            end
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < NREGS; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    // Over- or under-flowing a pending count means the datapath lost
    // track of an in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                assert (!(inc[i] && !dec[i] && sb_q[i] == 2'd3));
                assert (!(dec[i] && !inc[i] && sb_q[i] == 2'd0));
            end
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.id_rr_en     = id_rr_en;
    assign bus.rr_ex_en     = rr_ex_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_rr_flush  = id_rr_flush;
    assign bus.rr_ex_bubble = rr_ex_bubble;
    assign bus.ex_wb_bubble = ex_wb_bubble;
    assign bus.issue        = issue;
    assign bus.halted       = halted;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hold, RAW stalls, redirect,
// multi-cycle EX freeze, halt and re-reset.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.IW(3), .CNT_W(16)) bus ();

    pipe_hazard_ctrl #(
        .NREGS(8), .RESET_HOLD(4), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_rr(input logic v,
                          input logic u1, input logic [2:0] s1,
                          input logic u2, input logic [2:0] s2,
                          input logic wr, input logic [2:0] d);
        bus.rr_valid     = v;
        bus.rr_src1_used = u1;
        bus.rr_src1_idx  = s1;
        bus.rr_src2_used = u2;
        bus.rr_src2_idx  = s2;
        bus.rr_dst_wr    = wr;
        bus.rr_dst_idx   = d;
    endtask

    task automatic set_wb(input logic v, input logic wr,
                          input logic [2:0] d, input logic h);
        bus.wb_valid   = v;
        bus.wb_wr      = wr;
        bus.wb_dst_idx = d;
        bus.wb_halt    = h;
    endtask

    task automatic idle();
        set_rr(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0, 0);
        bus.ex_busy     = 1'b0;
        bus.ex_redirect = 1'b0;
    endtask

    task automatic hold_seq(input string tag);
        for (int k = 0; k < 4; k++) begin
            mid();
            check({tag, "_pc_en"}, 32'(bus.pc_en), 0);
            check({tag, "_flush"}, 32'(bus.if_id_flush), 1);
            nxt();
        end
        mid();
        check({tag, "_run_pc_en"}, 32'(bus.pc_en), 1);
    endtask

    initial begin
        idle();
        #2 rst = 1'b0;
        nxt();
        nxt();
        mid();
        check("rst_pc_en", 32'(bus.pc_en), 0);
        check("rst_if_flush", 32'(bus.if_id_flush), 1);
        check("rst_id_flush", 32'(bus.id_rr_flush), 1);
        check("rst_rr_ex_en", 32'(bus.rr_ex_en), 1);
        check("rst_rr_bub", 32'(bus.rr_ex_bubble), 1);
        check("rst_wb_bub", 32'(bus.ex_wb_bubble), 1);
        check("rst_issue", 32'(bus.issue), 0);
        check("rst_halted", 32'(bus.halted), 0);
        check("rst_stall", 32'(bus.stall_cnt), 0);
        nxt();
        rst = 1'b1;
        hold_seq("hold0");
        nxt();

        // EAX writer, then a reader stalled until WB retires it
        set_rr(1, 0, 0, 0, 0, 1, 0);
        mid();
        check("eax_wr_issue", 32'(bus.issue), 1);
        check("eax_wr_wbbub", 32'(bus.ex_wb_bubble), 0);
        nxt();
        set_rr(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            mid();
            check("eax_st_pc", 32'(bus.pc_en), 0);
            check("eax_st_bub", 32'(bus.rr_ex_bubble), 1);
            check("eax_st_iss", 32'(bus.issue), 0);
            nxt();
        end
        set_wb(1, 1, 0, 0);
        mid();
        check("eax_byp_iss", 32'(bus.issue), 1);
        check("eax_byp_pc", 32'(bus.pc_en), 1);
        nxt();
        idle();
        mid();
        check("eax_stall_cnt", 32'(bus.stall_cnt), 2);
        nxt();

        // two writes to ECX, reader waits for both retirements
        set_rr(1, 0, 0, 0, 0, 1, 1);
        mid();
        check("ecx_wr1_iss", 32'(bus.issue), 1);
        nxt();
        mid();
        check("ecx_wr2_iss", 32'(bus.issue), 1);
        nxt();
        set_rr(1, 0, 0, 1, 1, 0, 0);
        mid();
        check("ecx_st0_pc", 32'(bus.pc_en), 0);
        nxt();
        set_wb(1, 1, 1, 0);
        mid();
        check("ecx_st1_iss", 32'(bus.issue), 0);
        nxt();
        mid();
        check("ecx_byp_iss", 32'(bus.issue), 1);
        nxt();
        set_wb(0, 0, 0, 0);
        mid();
        check("ecx_zero_iss", 32'(bus.issue), 1);
        nxt();
        idle();
        mid();
        check("ecx_stall_cnt", 32'(bus.stall_cnt), 4);
        nxt();

        // redirect beats a pending EDX hazard
        set_rr(1, 0, 0, 0, 0, 1, 2);
        mid();
        check("edx_wr_iss", 32'(bus.issue), 1);
        nxt();
        set_rr(1, 1, 2, 0, 0, 1, 3);
        bus.ex_redirect = 1'b1;
        mid();
        check("redir_pc", 32'(bus.pc_en), 1);
        check("redir_if_fl", 32'(bus.if_id_flush), 1);
        check("redir_id_fl", 32'(bus.id_rr_flush), 1);
        check("redir_rr_en", 32'(bus.rr_ex_en), 1);
        check("redir_bub", 32'(bus.rr_ex_bubble), 1);
        check("redir_iss", 32'(bus.issue), 0);
        nxt();
        bus.ex_redirect = 1'b0;
        set_rr(1, 1, 2, 0, 0, 0, 0);
        mid();
        check("redir_sb2_kept", 32'(bus.pc_en), 0);
        nxt();
        set_rr(1, 1, 2, 1, 3, 0, 0);
        set_wb(1, 1, 2, 0);
        mid();
        check("redir_sb3_clean", 32'(bus.issue), 1);
        nxt();
        idle();
        mid();
        check("redir_stall_cnt", 32'(bus.stall_cnt), 5);
        nxt();

        // multi-cycle EX freezes the front end; redirect ignored
        set_rr(1, 0, 0, 0, 0, 0, 0);
        bus.ex_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.ex_redirect = (k == 1);
            mid();
            check("busy_pc", 32'(bus.pc_en), 0);
            check("busy_wbbub", 32'(bus.ex_wb_bubble), 1);
            check("busy_iss", 32'(bus.issue), 0);
            check("busy_flush", 32'(bus.if_id_flush), 0);
            nxt();
        end
        idle();
        mid();
        check("busy_stall_cnt", 32'(bus.stall_cnt), 8);
        nxt();

        // halt takes effect in the retiring cycle and sticks
        set_rr(1, 0, 0, 0, 0, 0, 0);
        set_wb(1, 0, 0, 1);
        mid();
        check("hlt_halted", 32'(bus.halted), 1);
        check("hlt_pc", 32'(bus.pc_en), 0);
        check("hlt_iss", 32'(bus.issue), 0);
        check("hlt_wbbub", 32'(bus.ex_wb_bubble), 1);
        nxt();
        set_wb(0, 0, 0, 0);
        mid();
        check("hlt2_halted", 32'(bus.halted), 1);
        check("hlt2_pc", 32'(bus.pc_en), 0);
        check("hlt2_rr_en", 32'(bus.rr_ex_en), 0);
        check("hlt2_if_en", 32'(bus.if_id_en), 0);
        check("hlt2_flush", 32'(bus.if_id_flush), 0);
        nxt();
        rst = 1'b0;
        mid();
        check("rr_halted", 32'(bus.halted), 0);
        check("rr_flush", 32'(bus.if_id_flush), 1);
        check("rr_stall", 32'(bus.stall_cnt), 0);
        check("rr_pc", 32'(bus.pc_en), 0);
        nxt();
        rst = 1'b1;
        idle();
        hold_seq("hold1");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage IF/ID/RR/EX/WB pipeline. It generates the PC and stage-register enables, flush and bubble controls. It tracks in-flight register writes in a scoreboard and stalls RR on read-after-write (RAW) hazards. It also freezes the front end during multi-cycle EX operations, squashes wrong-path instructions on EX redirect, and sequences the post-reset hold and the halt state.

Parameters:
NREGS, 8, architectural GPR count (EAX..EDI); register index width is clog2(NREGS)=3.
RESET_HOLD, 4, cycles after reset deassertion during which the pipeline is frozen and flushed.
CNT_W, 16, width of the stall performance counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
rr_valid  in  1  RR stage holds a valid instruction.
rr_src1_used / rr_src2_used  in  1  source operand read by the RR instruction.
rr_src1_idx / rr_src2_idx  in  3  source register indices.
rr_dst_wr  in  1  RR instruction writes a GPR.
rr_dst_idx  in  3  destination register index.
ex_busy  in  1  EX is in a multi-cycle operation; the EX result is not ready this cycle.
ex_redirect  in  1  valid EX instruction redirects control flow this cycle.
wb_valid  in  1  WB stage valid.
wb_wr  in  1  WB writes a GPR.
wb_dst_idx  in  3  WB destination index.
wb_halt  in  1  WB instruction is HLT.
pc_en  out  1  PC register load enable.
if_id_en / id_rr_en / rr_ex_en  out  1  pipeline register enables.
if_id_flush / id_rr_flush  out  1  clear the valid bit of the stage register.
rr_ex_bubble  out  1  load an invalid entry into RR/EX (qualified by rr_ex_en).
ex_wb_bubble  out  1  load an invalid entry into EX/WB.
issue  out  1  the RR instruction advances into EX this cycle.
halted  out  1  controller is in HALT.
stall_cnt  out  CNT_W  saturating count of RAW-stall plus ex_busy cycles.

Behaviour:
- FSM states: HOLD, RUN, HALT. The reset value is HOLD with hold_cnt=0, scoreboard all zero and stall_cnt=0.
- HOLD:
  - Outputs: all *_en=0; if_id_flush=id_rr_flush=1; rr_ex_en=1 with rr_ex_bubble=1; ex_wb_bubble=1; issue=0.
  - hold_cnt increments each cycle. When hold_cnt==RESET_HOLD-1 the FSM moves to RUN, so the first pc_en=1 occurs RESET_HOLD cycles after reset release.
- Scoreboard: one 2-bit pending count per register.
  - Increments when issue & rr_dst_wr for rr_dst_idx.
  - Decrements when wb_valid & wb_wr for wb_dst_idx.
  - A simultaneous increment and decrement on the same index leaves the count unchanged.
  - The count never exceeds 2 (EX plus WB in flight). An increment at 3 or a decrement at 0 is a design error; the implementation flags it with a simulation assertion.
- Hazard: true when a used source has a nonzero count, excluding the case where count==1 and WB retires that same index this cycle. That WB-to-RR bypass relies on the write-through register file.
- Control in RUN is evaluated in this priority order:
  - ex_busy: pc_en=if_id_en=id_rr_en=rr_ex_en=0, ex_wb_bubble=1, issue=0. ex_redirect is ignored while ex_busy=1.
  - ex_redirect: pc_en=1, if_id_en=id_rr_en=1, if_id_flush=id_rr_flush=1, rr_ex_en=1 with rr_ex_bubble=1, issue=0. The scoreboard is not incremented.
  - hazard & rr_valid: pc_en=if_id_en=id_rr_en=0, rr_ex_en=1 with rr_ex_bubble=1, issue=0.
  - otherwise: all enables=1, no flush or bubble, issue=rr_valid.
- stall_cnt increments in RUN on each cycle where ex_busy=1, or where a hazard stalls a valid RR instruction. It saturates at all-ones.
- HALT:
  - Entered from RUN when wb_valid & wb_halt. wb_halt has higher priority than all RUN rules in that cycle: the outputs follow HALT values in the same cycle.
  - Outputs: all enables=0, no flush, ex_wb_bubble=1, halted=1.
  - HALT is sticky until reset.
- Reset asserted mid-operation: every register returns to its reset value immediately and asynchronously, and the outputs take the HOLD values.

Test Plan:
- Reset release with RESET_HOLD=4 -> pc_en=0 for exactly 4 rising edges, then 1; flush=1 throughout HOLD.
- RR writes EAX (rr_dst_idx=0) then the next RR reads EAX -> 2 stall cycles with rr_ex_bubble=1 and pc_en=0; issue rises in the cycle WB retires idx 0; stall_cnt=2.
- Back-to-back writes to ECX (count reaches 2), then the reader of ECX -> stalls until both WB retirements; the count returns to 0.
- ex_redirect coincident with an RR hazard -> redirect wins: pc_en=1, both flushes=1, no stall; the scoreboard is unchanged.
- ex_busy held 3 cycles with rr_valid=1 -> front end frozen, ex_wb_bubble=1 for 3 cycles; stall_cnt +3; a simultaneous ex_redirect is ignored.
- wb_halt at WB -> halted=1 in the same cycle, all enables 0 thereafter; rst=0 for one cycle -> HOLD; RUN resumes after 4 cycles.
